// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator by R with a low-rate valid/ready
// input. The comb section runs at the low rate. Its output is zero-stuffed and
// fed to a full-rate integrator chain. The result is scaled back to unity DC gain.
//
// Optional feature macro: CIC_INTERP_UNDERRUN_HOLD_EN
//   defined   : an underrun slot re-injects the last accepted sample
//   undefined : an underrun slot injects zero
//
// state | meaning
// IDLE  | waiting for the first sample; phase held at 0; in_ready follows enable
// RUN   | streaming; one input slot every R enabled cycles (phase == 0)
module cic_interpolator #(
  parameter int BIT_WIDTH   = 4,
  parameter int STAGES      = 3,
  parameter int INTERP_RATE = 8,
  parameter int INT_WIDTH   = BIT_WIDTH + STAGES*$clog2(INTERP_RATE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [BIT_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [BIT_WIDTH-1:0] data_out,
  output logic                        data_valid,
  output logic                        underrun
);

  localparam int PW    = $clog2(INTERP_RATE);
  localparam int SHIFT = (STAGES-1)*PW;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [PW-1:0]               phase_q, phase_d;
  logic signed [INT_WIDTH-1:0] dly_q    [STAGES];
  logic signed [INT_WIDTH-1:0] dly_d    [STAGES];
  logic signed [INT_WIDTH-1:0] integ_q  [STAGES];
  logic signed [INT_WIDTH-1:0] integ_d  [STAGES];
  logic signed [INT_WIDTH-1:0] stage_x  [STAGES+1];
  logic signed [INT_WIDTH-1:0] comb_out_q, comb_out_d;
  logic signed [INT_WIDTH-1:0] upsamp;
  logic signed [BIT_WIDTH-1:0] data_out_q, data_out_d;
  logic signed [BIT_WIDTH-1:0] sample;
  logic                        data_valid_q, data_valid_d;
  logic                        accept, slot, take, run_en, adv;
`ifdef CIC_INTERP_UNDERRUN_HOLD_EN
  logic signed [BIT_WIDTH-1:0] held_q, held_d;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: the first handshake starts the stream, only rst stops it
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE && accept) state_d = S_RUN;
  end

  // FSM outputs: handshake and slot decode, never dependent on in_valid for ready
  always_comb begin
    in_ready = !rst && enable && (state_q == S_IDLE || phase_q == '0);
    slot     = !rst && enable && state_q == S_RUN && phase_q == '0;
    accept   = in_valid && in_ready;
    underrun = slot && !in_valid;
    take     = accept || underrun;
    run_en   = enable && state_q == S_RUN;
    // the accepting IDLE cycle acts as phase 0 of the stream
    adv      = run_en || (state_q == S_IDLE && accept);
  end

  // datapath next-state: low-rate comb chain, zero stuffing, integrator chain
  always_comb begin
`ifdef CIC_INTERP_UNDERRUN_HOLD_EN
    held_d = accept ? in_data : held_q;
    sample = accept ? in_data : held_q;
`else
    sample = accept ? in_data : '0;
`endif
    stage_x[0] = {{(INT_WIDTH-BIT_WIDTH){sample[BIT_WIDTH-1]}}, sample};
    for (int i = 0; i < STAGES; i++) begin
      stage_x[i+1] = stage_x[i] - dly_q[i];
      dly_d[i]     = take ? stage_x[i] : dly_q[i];
    end
    comb_out_d = take ? stage_x[STAGES] : comb_out_q;

    // comb_out is fresh exactly on the cycle after a slot, i.e. phase 1
    upsamp = (phase_q == PW'(1)) ? comb_out_q : '0;

    integ_d[0] = run_en ? integ_q[0] + upsamp : integ_q[0];
    for (int i = 1; i < STAGES; i++)
      integ_d[i] = run_en ? integ_q[i] + integ_q[i-1] : integ_q[i];

    data_out_d   = run_en ? integ_q[STAGES-1][SHIFT+BIT_WIDTH-1:SHIFT] : data_out_q;
    data_valid_d = run_en;
    phase_d      = adv ? phase_q + PW'(1) : phase_q;
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      comb_out_q   <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        dly_q[i]   <= '0;
        integ_q[i] <= '0;
      end
`ifdef CIC_INTERP_UNDERRUN_HOLD_EN
      held_q       <= '0;
`endif
    end else begin
      phase_q      <= phase_d;
      comb_out_q   <= comb_out_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      for (int i = 0; i < STAGES; i++) begin
        dly_q[i]   <= dly_d[i];
        integ_q[i] <= integ_d[i];
      end
`ifdef CIC_INTERP_UNDERRUN_HOLD_EN
      held_q       <= held_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Testbench for cic_interpolator. The reference model treats the filter as an
// LTI system: the zero-stuffed input is convolved with the boxcar^N impulse
// response, delayed, and then divided by R^(N-1) with floor.
module tb_cic_interpolator;
  localparam int BW   = 4;
  localparam int N    = 3;
  localparam int R    = 8;
  localparam int SH   = (N-1)*$clog2(R);
  localparam int HLEN = N*(R-1)+1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic signed [BW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BW-1:0] data_out;
  logic                 data_valid;
  logic                 underrun;

  cic_interpolator #(.BIT_WIDTH(BW), .STAGES(N), .INTERP_RATE(R)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
    .data_valid(data_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  int                   h [HLEN];
  bit                   started;
  int                   n;
  int                   xs [$];
  int                   last_acc;
  logic signed [BW-1:0] exp_out;
  logic                 exp_valid;
  logic                 seen_rdy, seen_ur;

  function automatic void build_h();
    int cur [HLEN];
    int nxt [HLEN];
    int len;
    foreach (cur[i]) cur[i] = 0;
    cur[0] = 1;
    len = 1;
    for (int s = 0; s < N; s++) begin
      foreach (nxt[i]) nxt[i] = 0;
      for (int i = 0; i < len; i++)
        for (int k = 0; k < R; k++) nxt[i+k] += cur[i];
      len = len + R - 1;
      cur = nxt;
    end
    h = cur;
  endfunction

  // output register value after enabled stream cycle idx
  function automatic logic signed [BW-1:0] model_out(input int idx);
    int acc = 0;
    int q;
    int t;
    for (int m = 0; m < xs.size(); m++) begin
      t = idx - (N+1) - m*R;
      if (t >= 0 && t < HLEN) acc += xs[m] * h[t];
    end
    q = acc >>> SH;
    return BW'(q);
  endfunction

  task automatic model_reset();
    started   = 1'b0;
    n         = 0;
    xs.delete();
    last_acc  = 0;
    exp_out   = '0;
    exp_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst = 1'b1; enable = 1'b1; in_valid = 1'b1; in_data = 4'sd5;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
      checks++;
      if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun cyc=%0d got=%b exp=0", cyc, underrun); end
      @(posedge clk); #1; cyc++;
      checks++;
      if (data_out !== '0 || data_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_outputs cyc=%0d got data_out=%0d valid=%b exp 0/0", cyc, data_out, data_valid);
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  // one clock cycle: check registered outputs, drive, check combinational outputs
  task automatic run_cycle(input bit en, input bit vld, input int d);
    logic exp_rdy, exp_ur;
    int   smp;
    checks++;
    if (data_valid !== exp_valid) begin failures++; $display("FAIL data_valid cyc=%0d got=%b exp=%b", cyc, data_valid, exp_valid); end
    checks++;
    if (data_out !== exp_out) begin failures++; $display("FAIL data_out cyc=%0d got=%0d exp=%0d", cyc, data_out, exp_out); end
    enable = en; in_valid = vld; in_data = BW'(d);
    #1;
    exp_rdy = en && (!started || (n % R) == 0);
    exp_ur  = en && started && (n % R) == 0 && !vld;
    seen_rdy = in_ready;
    seen_ur  = underrun;
    checks++;
    if (in_ready !== exp_rdy) begin failures++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
    checks++;
    if (underrun !== exp_ur) begin failures++; $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, underrun, exp_ur); end
    if (en) begin
      if (!started) begin
        if (vld) begin started = 1'b1; xs.push_back(d); last_acc = d; n = 1; end
        exp_valid = 1'b0;
      end else begin
        if ((n % R) == 0) begin
`ifdef CIC_INTERP_UNDERRUN_HOLD_EN
          smp = vld ? d : last_acc;
`else
          smp = vld ? d : 0;
`endif
          if (vld) last_acc = d;
          xs.push_back(smp);
        end
        exp_valid = 1'b1;
        exp_out   = model_out(n);
        n++;
      end
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic test_reset();
    do_reset(3);
    run_cycle(1'b1, 1'b1, 3);
    checks++;
    if (seen_rdy !== 1'b1) begin failures++; $display("FAIL first_accept got in_ready=%b exp=1", seen_rdy); end
    for (int i = 0; i < 16; i++) run_cycle(1'b1, 1'b1, 3);
  endtask

  task automatic test_dc(input int val);
    do_reset(1);
    for (int i = 0; i < 2*N*R + 2*R; i++) run_cycle(1'b1, 1'b1, val);
    checks++;
    if (data_out !== BW'(val)) begin failures++; $display("FAIL dc_settle got=%0d exp=%0d", data_out, val); end
  endtask

  task automatic test_handshake();
    int pulses = 0;
    int first_nz = -1;
    do_reset(1);
    for (int i = 0; i < 8*R; i++) begin
      if (first_nz < 0 && started && data_out !== '0) first_nz = n;
      run_cycle(1'b1, 1'b1, -8);
      if (seen_rdy) pulses++;
    end
    checks++;
    if (pulses != 8) begin failures++; $display("FAIL ready_pulses got=%0d exp=8", pulses); end
    checks++;
    if (first_nz != N+2) begin failures++; $display("FAIL first_output got=%0d exp=%0d", first_nz, N+2); end
  endtask

  task automatic test_underrun();
    int urs = 0;
    int mn  = 100;
    do_reset(1);
    for (int i = 0; i < 12*R; i++) begin
      if (i > 6*R && int'(data_out) < mn) mn = int'(data_out);
      run_cycle(1'b1, i != 6*R, 2);
      if (seen_ur) urs++;
    end
    checks++;
    if (urs != 1) begin failures++; $display("FAIL underrun_count got=%0d exp=1", urs); end
    checks++;
    if (data_out !== 4'sd2) begin failures++; $display("FAIL underrun_recover got=%0d exp=2", data_out); end
`ifdef CIC_INTERP_UNDERRUN_HOLD_EN
    checks++;
    if (mn != 2) begin failures++; $display("FAIL underrun_hold min got=%0d exp=2", mn); end
`else
    checks++;
    if (mn >= 2) begin failures++; $display("FAIL underrun_dip min got=%0d exp below 2", mn); end
`endif
  endtask

  task automatic test_enable_freeze();
    do_reset(1);
    for (int i = 0; i < 40; i++) run_cycle(1'b1, 1'b1, int'($urandom_range(0, 15)) - 8);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b1, 7);
    for (int i = 0; i < 40; i++) run_cycle(1'b1, 1'b1, int'($urandom_range(0, 15)) - 8);
  endtask

  task automatic test_reset_mid_run();
    int guard = 0;
    do_reset(1);
    while (!(started && (n % R) == 4) && guard < 100) begin
      run_cycle(1'b1, 1'b1, 5);
      guard++;
    end
    for (int i = 0; i < R; i++) run_cycle(1'b1, 1'b1, 5);
    guard = 0;
    while ((n % R) != 4 && guard < 100) begin
      run_cycle(1'b1, 1'b1, 5);
      guard++;
    end
    checks++;
    if (guard >= 100) begin failures++; $display("FAIL mid_reset_phase got timeout exp phase 4"); end
    do_reset(1);
    for (int i = 0; i < 6*R; i++) run_cycle(1'b1, 1'b1, 5);
  endtask

  task automatic test_random();
    do_reset(1);
    for (int i = 0; i < 400; i++)
      run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
                int'($urandom_range(0, 15)) - 8);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    build_h();
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_dc(3);
    test_dc(-8);
    test_handshake();
    test_underrun();
    test_enable_freeze();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
